// File: rtl/div_if.sv
// div_if: request/response bundle between the pipeline and the iterative divider
interface div_if #(parameter int XLEN = 64);
  logic            start_i;
  logic            signed_i;
  logic            word_i;
  logic            rem_i;
  logic            cancel_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic [XLEN-1:0] result_o;
  logic            ready_o;
  logic            busy_o;
  logic            stallreq_o;
  modport master (
    output start_i, signed_i, word_i, rem_i, cancel_i, dividend_i, divisor_i,
    input  result_o, ready_o, busy_o, stallreq_o
  );
  modport slave (
    input  start_i, signed_i, word_i, rem_i, cancel_i, dividend_i, divisor_i,
    output result_o, ready_o, busy_o, stallreq_o
  );
endinterface

// File: rtl/div_ctrl.sv
// div_ctrl: restoring radix-2 divider for div/divu/rem/remu and their W forms, one quotient bit per cycle
module div_ctrl #(parameter int XLEN = 64) (
  input logic clk,
  input logic rst,
  div_if.slave d
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
  state_e state_q, state_d;
  logic [XLEN-1:0] q_q, q_d, acc_q, acc_d, b_q, b_d, result_q, result_d;
  logic [5:0] cnt_q, cnt_d;
  logic word_q, word_d, rsel_q, rsel_d, negq_q, negq_d, negr_q, negr_d;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, spec_sel, q_fix, r_fix;
  logic [XLEN:0] sh, sub;
  logic a_neg, b_neg, div_zero, ovf, ge, last;
  function automatic logic [XLEN-1:0] fmt(input logic w, input logic [XLEN-1:0] v);
    return w ? {{32{v[31]}}, v[31:0]} : v;
  endfunction
  always_comb begin
    a_ext = d.word_i ? {{32{d.signed_i & d.dividend_i[31]}}, d.dividend_i[31:0]} : d.dividend_i;
    b_ext = d.word_i ? {{32{d.signed_i & d.divisor_i[31]}}, d.divisor_i[31:0]} : d.divisor_i;
    a_neg = d.signed_i & a_ext[XLEN-1];
    b_neg = d.signed_i & b_ext[XLEN-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
    div_zero = b_ext == '0;
    ovf = d.signed_i & (b_ext == '1)
        & (a_ext == (d.word_i ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    spec_sel = div_zero ? (d.rem_i ? d.dividend_i : '1) : (d.rem_i ? '0 : d.dividend_i);
    sh = {acc_q, q_q[XLEN-1]};
    sub = sh - {1'b0, b_q};
    ge = sh >= {1'b0, b_q};
    last = cnt_q == (word_q ? 6'd31 : 6'd63);
    q_fix = negq_q ? -q_q : q_q;
    r_fix = negr_q ? -acc_q : acc_q;
  end
  always_comb begin
    state_d = state_q;
    q_d = q_q;
    acc_d = acc_q;
    b_d = b_q;
    cnt_d = cnt_q;
    word_d = word_q;
    rsel_d = rsel_q;
    negq_d = negq_q;
    negr_d = negr_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (d.start_i) begin
        word_d = d.word_i;
        rsel_d = d.rem_i;
        negq_d = a_neg ^ b_neg;
        negr_d = a_neg;
        b_d = b_mag;
        acc_d = '0;
        cnt_d = '0;
        // word operands sit in the top half so 32 shifts leave the quotient in the low half
        q_d = d.word_i ? {a_mag[31:0], 32'b0} : a_mag;
        result_d = (div_zero | ovf) ? fmt(d.word_i, spec_sel) : result_q;
        state_d = (div_zero | ovf) ? DONE : CALC;
      end
      CALC: begin
        acc_d = ge ? sub[XLEN-1:0] : sh[XLEN-1:0];
        q_d = {q_q[XLEN-2:0], ge};
        cnt_d = last ? '0 : cnt_q + 6'd1;
        state_d = last ? FIX : CALC;
      end
      FIX: begin
        result_d = fmt(word_q, rsel_q ? r_fix : q_fix);
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (d.cancel_i) begin
      state_d = IDLE;
      cnt_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q <= '0;
      acc_q <= '0;
      b_q <= '0;
      cnt_q <= '0;
      word_q <= 1'b0;
      rsel_q <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      q_q <= q_d;
      acc_q <= acc_d;
      b_q <= b_d;
      cnt_q <= cnt_d;
      word_q <= word_d;
      rsel_q <= rsel_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      result_q <= result_d;
    end
  end
  assign d.result_o = result_q;
  assign d.ready_o = state_q == DONE;
  assign d.busy_o = state_q != IDLE;
  assign d.stallreq_o = !rst & ((state_q == IDLE & d.start_i & !d.cancel_i) | state_q == CALC | state_q == FIX);
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: scoreboard bench for div_ctrl against a plain-arithmetic RISC-V divide model
module tb_div_ctrl;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  div_if #(64) d();
  div_ctrl #(.XLEN(64)) dut (.clk(clk), .rst(rst), .d(d));
  typedef struct {logic [63:0] res; int lat; int st;} exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0, ncyc = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction
  function automatic logic [63:0] ext(input logic s, input logic w, input logic [63:0] v);
    return !w ? v : (s ? sx(v[31:0]) : {32'b0, v[31:0]});
  endfunction
  function automatic bit special(input logic s, input logic w, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] ae, be;
    ae = ext(s, w, a);
    be = ext(s, w, b);
    return be == 0 || (s && be == '1 && ae == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
  endfunction
  function automatic logic [63:0] ref_div(input logic s, input logic w, input logic r, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] ae, be, q, rm, res;
    ae = ext(s, w, a);
    be = ext(s, w, b);
    if (be == 0) begin
      q = '1;
      rm = ae;
    end else if (special(s, w, a, b)) begin
      q = ae;
      rm = 0;
    end else if (s) begin
      q = $signed(ae) / $signed(be);
      rm = $signed(ae) % $signed(be);
    end else begin
      q = ae / be;
      rm = ae % be;
    end
    res = r ? rm : q;
    return w ? sx(res[31:0]) : res;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (d.ready_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_ready actual=1 required=0");
      end else begin
        e = sb.pop_front();
        chk("result", d.result_o, e.res);
        chk("latency", 64'(ncyc - e.st), 64'(e.lat));
      end
    end
  end
  task automatic run(input logic s, input logic w, input logic r, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    d.start_i = 1;
    d.signed_i = s;
    d.word_i = w;
    d.rem_i = r;
    d.dividend_i = a;
    d.divisor_i = b;
    e.res = ref_div(s, w, r, a, b);
    e.lat = special(s, w, a, b) ? 1 : (w ? 34 : 66);
    e.st = ncyc + 1;
    sb.push_back(e);
    @(negedge clk); #1;
    chk("stall_start", d.stallreq_o, 1);
    @(posedge clk); #1;
    d.start_i = 0;
    d.signed_i = 1'($urandom);
    d.word_i = 1'($urandom);
    d.rem_i = 1'($urandom);
    d.dividend_i = {$urandom, $urandom};
    d.divisor_i = {$urandom, $urandom};
    for (int i = 1; i <= e.lat; i++) begin
      @(negedge clk); #1;
      chk("stall_run", d.stallreq_o, i < e.lat);
    end
    chk("ready_seen", 64'(sb.size()), 0);
    sb.delete();
    @(posedge clk); #1;
  endtask
  initial begin
    logic s, w, r;
    logic [63:0] a, b;
    #1000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
  initial begin
    logic s, w, r;
    logic [63:0] a, b;
    d.start_i = 1;
    d.signed_i = 0;
    d.word_i = 0;
    d.rem_i = 0;
    d.cancel_i = 0;
    d.dividend_i = 9;
    d.divisor_i = 3;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", d.stallreq_o, 0);
    chk("rst_busy", d.busy_o, 0);
    chk("rst_ready", d.ready_o, 0);
    chk("rst_result", d.result_o, 0);
    rst = 0;
    run(0, 0, 0, 100, 7);
    run(0, 0, 1, 100, 7);
    run(1, 0, 0, -64'sd7, 2);
    run(1, 0, 1, -64'sd7, 2);
    run(0, 0, 0, 5, 0);
    run(0, 0, 1, 5, 0);
    run(1, 0, 0, 64'h8000_0000_0000_0000, '1);
    run(1, 1, 0, 64'h8000_0000, 64'hFFFF_FFFF);
    run(1, 1, 1, 64'h8000_0000, 64'hFFFF_FFFF);
    run(0, 1, 0, 64'hFFFF_FFFF, 1);
    d.start_i = 1;
    d.cancel_i = 1;
    @(negedge clk); #1;
    chk("cancel_prio_stall", d.stallreq_o, 0);
    @(posedge clk); #1;
    d.start_i = 0;
    d.cancel_i = 0;
    chk("cancel_prio_busy", d.busy_o, 0);
    d.start_i = 1;
    d.dividend_i = 1000;
    d.divisor_i = 3;
    @(posedge clk); #1;
    d.start_i = 0;
    repeat (9) @(posedge clk);
    #1;
    d.cancel_i = 1;
    @(posedge clk); #1;
    d.cancel_i = 0;
    chk("cancel_busy", d.busy_o, 0);
    chk("cancel_ready", d.ready_o, 0);
    run(0, 0, 0, 1000, 3);
    run(0, 1, 0, 64'hFFFF_FFFF, 1);
    d.start_i = 1;
    d.word_i = 0;
    d.dividend_i = 12345;
    d.divisor_i = 11;
    @(posedge clk); #1;
    d.start_i = 0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1;
    @(negedge clk); #1;
    chk("rst_mid_stall", d.stallreq_o, 0);
    @(posedge clk); #1;
    chk("rst_mid_busy", d.busy_o, 0);
    chk("rst_mid_ready", d.ready_o, 0);
    chk("rst_mid_result", d.result_o, 0);
    rst = 0;
    run(1, 0, 1, 12345, -64'sd11);
    for (int k = 0; k < 40; k++) begin
      s = 1'($urandom);
      w = 1'($urandom);
      r = 1'($urandom);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(0, 63);
      case ($urandom_range(0, 5))
        0: b = w ? {$urandom, 32'b0} : 0;
        1: begin
          b = w ? {$urandom, 32'hFFFF_FFFF} : '1;
          a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
        end
        2: a = a >> $urandom_range(0, 63);
        default: ;
      endcase
      run(s, w, r, a, b);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width; only 64 is supported.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start_i  input  1  request a divide; sampled only in IDLE.
REQ-005 SHALL have port signed_i  input  1  1 = div/rem (signed), 0 = divu/remu.
REQ-006 SHALL have port word_i  input  1  1 = W-variant (operands [31:0], 32-bit result sign-extended).
REQ-007 SHALL have port rem_i  input  1  1 = return remainder, 0 = return quotient.
REQ-008 SHALL have port dividend_i  input  64  rs1 operand.
REQ-009 SHALL have port divisor_i  input  64  rs2 operand.
REQ-010 SHALL have port cancel_i  input  1  flush; abort any in-flight operation.
REQ-011 SHALL have port result_o  output  64  registered result, valid while ready_o=1.
REQ-012 SHALL have port ready_o  output  1  result valid; one-cycle pulse.
REQ-013 SHALL have port busy_o  output  1  state != IDLE.
REQ-014 SHALL have port stallreq_o  output  1  pipeline stall request.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-016 IDLE: start_i=1 and cancel_i=0 SHALL latch all operand and control inputs; if the special case of REQ-021/REQ-022 applies -> DONE, else -> CALC.
REQ-017 CALC SHALL perform one restoring radix-2 iteration per cycle on operand magnitudes: K=64 iterations (word_i=0) or K=32 (word_i=1), counted by an iteration counter; the last iteration -> FIX.
REQ-018 FIX SHALL apply sign correction: quotient negated iff signed and operand signs differ; remainder takes the dividend sign; then select per rem_i, sign-extend bit 31 if word_i, register into result_o -> DONE.
REQ-019 DONE SHALL assert ready_o for exactly one cycle and then -> IDLE unconditionally; start_i in DONE is ignored.
REQ-020 Latency: ready_o SHALL be high K+2 cycles after the start-sample cycle (66 for 64-bit, 34 for word); special cases 1 cycle.
REQ-021 Divisor zero (in the effective width) SHALL give quotient all-ones and remainder = dividend, sign-extended from bit 31 when word_i.
REQ-022 Signed overflow (most-negative / -1 in the effective width) SHALL give quotient = dividend and remainder 0.
REQ-023 Word operands SHALL be sign-extended from bit 31 when signed_i=1, else zero-extended, before division.
REQ-024 stallreq_o SHALL be combinational: 1 when (IDLE and start_i and !cancel_i) or state is CALC or FIX; 0 in DONE and idle.
REQ-025 cancel_i=1 in any state SHALL force IDLE at the next edge with no ready_o pulse; it has priority over start_i.
REQ-026 Operand inputs SHALL NOT affect an operation after the start-sample cycle.

Reset
REQ-027 rst=1 SHALL force IDLE, ready_o=0, busy_o=0, result_o=0, and the iteration counter to 0 at the next edge, including mid-CALC; stallreq_o SHALL be 0 while rst=1.
REQ-028 The first start_i SHALL be accepted in the first cycle after rst deasserts.

Verification
REQ-029 divu 100/7 (rem_i=0) -> result_o=14, ready_o exactly 66 cycles after start; remu -> 2.
REQ-030 div -7/2 -> 0xFFFF_FFFF_FFFF_FFFD; rem -> 0xFFFF_FFFF_FFFF_FFFF; stallreq_o high from the start cycle until DONE.
REQ-031 divu 5/0 -> 0xFFFF_FFFF_FFFF_FFFF; remu 5/0 -> 5; each with ready_o 1 cycle after start.
REQ-032 div 0x8000_0000_0000_0000/-1 -> 0x8000_0000_0000_0000; divw 0x8000_0000/0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000; remw -> 0; each 1-cycle latency.
REQ-033 divuw 0xFFFF_FFFF/1 -> 0xFFFF_FFFF_FFFF_FFFF with ready_o 34 cycles after start.
REQ-034 cancel_i at CALC iteration 10 -> IDLE next cycle with no ready_o, and a new start is accepted the cycle after; rst at iteration 20 -> all outputs 0 next cycle.
